bus_reg_slave: RTL and testbench



---
 rtl/bus_reg_pkg.sv | 19 +
 rtl/bus_reg_slave_if.sv | 38 +++
 rtl/bus_reg_array.sv | 44 ++++
 rtl/bus_reg_slave.sv | 82 ++++++++
 tb/tb_bus_reg_slave.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/bus_reg_pkg.sv
// rtl/bus_reg_pkg.sv - shared types and constants for the bus_reg_slave register endpoint
package bus_reg_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_reg_state_t;

    // Response struct is sized for the widest supported word; narrower builds zero-extend.
    localparam int BUS_REG_MAX_DW = 64;

    typedef struct packed {
        logic [BUS_REG_MAX_DW-1:0] rdata;
        logic                      err;
    } bus_reg_rsp_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/bus_reg_slave_if.sv
// rtl/bus_reg_slave_if.sv - request/response bus between a local master and bus_reg_slave (BUS_REG_SLAVE_WSTRB_EN adds req_wstrb)
interface bus_reg_slave_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
`ifdef BUS_REG_SLAVE_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] req_wstrb;
`endif
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
`ifdef BUS_REG_SLAVE_WSTRB_EN
        input  req_wstrb,
`endif
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
`ifdef BUS_REG_SLAVE_WSTRB_EN
        output req_wstrb,
`endif
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/bus_reg_array.sv
// rtl/bus_reg_array.sv - DEPTH x DATA_WIDTH register storage, sync write, comb read, async clear (BUS_REG_SLAVE_WSTRB_EN adds byte enables)
module bus_reg_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
`ifdef BUS_REG_SLAVE_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
`endif
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
`ifdef BUS_REG_SLAVE_WSTRB_EN
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
`else
            mem_q[wr_addr_i] <= wr_data_i;
`endif
        end
    end

    // Unimplemented addresses read as zero rather than indexing past the array.
    assign rd_data_o = ({1'b0, rd_addr_i} < DEPTH_W) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/bus_reg_slave.sv
// rtl/bus_reg_slave.sv - valid/ready register-file slave: handshake FSM, range check, error counter (BUS_REG_SLAVE_WSTRB_EN enables byte strobes)
module bus_reg_slave
    import bus_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 12
) (
    input  logic            clk,
    input  logic            rst,
    bus_reg_slave_if.slave  bus,
    output logic [7:0]      err_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    bus_reg_state_t        state_q, state_d;
    bus_reg_rsp_t          rsp_q, rsp_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  req_fire, rsp_fire, in_range, wr_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_rdata_hi;

    assign bus.req_ready = (state_q == IDLE) || bus.rsp_ready;
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign rsp_fire      = (state_q == RESP) && bus.rsp_ready;
    assign in_range      = {1'b0, bus.req_addr} < DEPTH_W;
    assign wr_en         = req_fire && bus.req_write && in_range;

    bus_reg_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (bus.req_addr),
        .wr_data_i (bus.req_wdata),
`ifdef BUS_REG_SLAVE_WSTRB_EN
        .wr_be_i   (bus.req_wstrb),
`endif
        .rd_addr_i (bus.req_addr),
        .rd_data_o (rd_data)
    );

    // A new request fire always wins over returning to IDLE: it reloads the response.
    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        err_cnt_d = err_cnt_q;
        if (req_fire) begin
            state_d   = RESP;
            rsp_d.err = !in_range;
            rsp_d.rdata = (bus.req_write || !in_range) ? '0 : BUS_REG_MAX_DW'(rd_data);
            if (!in_range && (err_cnt_q != ERR_COUNT_MAX)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (rsp_fire) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rsp_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_q.rdata[DATA_WIDTH-1:0];
    assign bus.rsp_err   = rsp_q.err;
    assign err_count     = err_cnt_q;
    assign unused_rdata_hi = ^rsp_q.rdata;

endmodule

// File: tb/tb_bus_reg_slave.sv
// tb/tb_bus_reg_slave.sv - directed self-checking bench for bus_reg_slave (strobe steps under BUS_REG_SLAVE_WSTRB_EN)
module tb_bus_reg_slave;

`ifdef BUS_REG_SLAVE_WSTRB_EN
    localparam int DW = 16;
`else
    localparam int DW = 8;
`endif
    localparam int AW    = 4;
    localparam int DEPTH = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] err_count;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    bus_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bus_reg_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW/8-1:0] s);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
`ifdef BUS_REG_SLAVE_WSTRB_EN
        bus.req_wstrb = s;
`else
        if (s == '0) bus.req_wdata = d;
`endif
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef BUS_REG_SLAVE_WSTRB_EN
        bus.req_wstrb = '1;
`endif
        bus.rsp_ready = 1'b1;

        #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b1, 4'd3, DW'(8'hA5), '1);
        check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
        issue(1'b0, 4'd3, '0, '1);
        check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'hA5);
        check("rd_rsp_err", 32'(bus.rsp_err), 32'd0);

        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 4'd3;
        bus.req_wdata = DW'(8'h11);
        #1;
        check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_rdata", 32'(bus.rsp_rdata), 32'hA5);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("bp_wr_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("bp_wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        issue(1'b0, 4'd3, '0, '1);
        check("bp_readback", 32'(bus.rsp_rdata), 32'h11);

        issue(1'b1, 4'd13, DW'(8'hFF), '1);
        check("oor13_err", 32'(bus.rsp_err), 32'd1);
        check("oor13_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("oor13_err_count", 32'(err_count), 32'd1);
        issue(1'b0, 4'd12, '0, '1);
        check("oor12_err", 32'(bus.rsp_err), 32'd1);
        check("oor12_err_count", 32'(err_count), 32'd2);
        issue(1'b0, 4'd11, '0, '1);
        check("inr11_err", 32'(bus.rsp_err), 32'd0);
        check("inr11_err_count", 32'(err_count), 32'd2);
        for (int a = 0; a < DEPTH; a++) begin
            issue(1'b0, AW'(a), '0, '1);
            check("regs_unchanged", 32'(bus.rsp_rdata), (a == 3) ? 32'h11 : 32'd0);
        end
        @(posedge clk);
        #1;
        check("idle_after_rsp", 32'(bus.rsp_valid), 32'd0);

        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'd3, '0, '1);
        check("pre_rst_rdata", 32'(bus.rsp_rdata), 32'h11);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        issue(1'b0, 4'd5, '0, '1);
        check("post_rst_addr5", 32'(bus.rsp_rdata), 32'd0);
        issue(1'b0, 4'd3, '0, '1);
        check("post_rst_addr3", 32'(bus.rsp_rdata), 32'd0);

        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'd15;
        repeat (254) @(posedge clk);
        #1;
        check("sat_254", 32'(err_count), 32'd254);
        @(posedge clk);
        #1;
        check("sat_255", 32'(err_count), 32'd255);
        repeat (45) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("sat_300", 32'(err_count), 32'd255);
        check("sat_rsp_err", 32'(bus.rsp_err), 32'd1);

`ifdef BUS_REG_SLAVE_WSTRB_EN
        issue(1'b1, 4'd2, 16'h1234, 2'b11);
        issue(1'b1, 4'd2, 16'hABCD, 2'b10);
        check("strb_wr_err", 32'(bus.rsp_err), 32'd0);
        check("strb_wr_rdata", 32'(bus.rsp_rdata), 32'd0);
        issue(1'b0, 4'd2, '0, '1);
        check("strb_merge", 32'(bus.rsp_rdata), 32'hAB34);
        issue(1'b1, 4'd2, 16'hFFFF, 2'b00);
        check("strb_zero_err", 32'(bus.rsp_err), 32'd0);
        check("strb_zero_valid", 32'(bus.rsp_valid), 32'd1);
        issue(1'b0, 4'd2, '0, '1);
        check("strb_zero_noop", 32'(bus.rsp_rdata), 32'hAB34);
`else
        issue(1'b1, 4'd2, 8'h3C, '1);
        issue(1'b1, 4'd2, 8'hC3, '1);
        issue(1'b0, 4'd2, '0, '1);
        check("full_word_write", 32'(bus.rsp_rdata), 32'hC3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
